// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_ext_sram.sv
// Simple dual-port RAM: port A writes, port B reads with a registered output.
module sram #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              CLK,
  input  logic              ENA,
  input  logic [AWIDTH-1:0] ADDRA,
  input  logic [DWIDTH-1:0] DINA,
  input  logic              ENB,
  input  logic [AWIDTH-1:0] ADDRB,
  output logic [DWIDTH-1:0] DOUTB
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge CLK) begin
    if (ENA) mem[ADDRA] <= DINA;
  end

  always_ff @(posedge CLK) begin
    if (ENB) DOUTB <= mem[ADDRB];
  end

endmodule

// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO over the dual-port sram with standard or first-word-fall-through
// output, occupancy count, programmable almost flags, flush and error pulses.
module fifo_sync_ext
  import fifo_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int ADEPTH     = 5,
  parameter int FWFT       = FIFO_STD,
  parameter int AFULL_LVL  = (2**ADEPTH) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              WR_EN,
  input  logic [DWIDTH-1:0] DIN,
  output logic              FULL,
  output logic              ALMOST_FULL,
  output logic              OVERFLOW,
  input  logic              RD_EN,
  output logic [DWIDTH-1:0] DOUT,
  output logic              EMPTY,
  output logic              ALMOST_EMPTY,
  output logic              UNDERFLOW,
  output logic [ADEPTH:0]   USED
);

  localparam int DEPTH   = 2**ADEPTH;
  localparam int CW      = clog2(DEPTH + 1);
  localparam bit IS_FWFT = (FWFT == FIFO_FWFT);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

  logic [ADEPTH:0] wr_ptr;
  logic [ADEPTH:0] rd_ptr;
  logic [CW-1:0]   used;
  logic            vld_p1;
  logic [ADEPTH:0] ram_cnt;
  logic            wr_acc;
  logic            rd_acc;
  logic            enb;
  logic            hold;

  // Flags come only from registered state.
  assign FULL         = (used == DEPTH_C);
  assign ALMOST_FULL  = (used >= AFULL_C);
  assign ALMOST_EMPTY = (used <= AEMPTY_C);
  assign EMPTY        = IS_FWFT ? ~vld_p1 : (used == '0);
  assign USED         = used;

  assign hold   = RST | FLUSH;
  assign wr_acc = WR_EN & ~FULL & ~hold;
  assign rd_acc = RD_EN & ~EMPTY & ~hold;

  // Words still in the RAM; in FWFT this excludes the word already on DOUT,
  // since its slot was released when it was prefetched.
  assign ram_cnt = wr_ptr - rd_ptr;
  assign enb     = IS_FWFT ? ((ram_cnt != '0) & (~vld_p1 | rd_acc) & ~hold) : rd_acc;

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      used      <= '0;
      vld_p1    <= 1'b0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + {{ADEPTH{1'b0}}, wr_acc};
      rd_ptr    <= rd_ptr + {{ADEPTH{1'b0}}, enb};
      used      <= used + CW'(wr_acc) - CW'(rd_acc);
      vld_p1    <= IS_FWFT & (enb | (vld_p1 & ~rd_acc));
      OVERFLOW  <= WR_EN & FULL;
      UNDERFLOW <= RD_EN & EMPTY;
    end
  end

  // ---- RAM read stage: DOUTB registered one edge after ENB ----
  sram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (ADEPTH)
  ) u_sram (
    .CLK   (CLK),
    .ENA   (wr_acc),
    .ADDRA (wr_ptr[ADEPTH-1:0]),
    .DINA  (DIN),
    .ENB   (enb),
    .ADDRB (rd_ptr[ADEPTH-1:0]),
    .DOUTB (DOUT)
  );

endmodule

// File: tb/tb_fifo_sync_ext.sv
// Bench for fifo_sync_ext: standard and FWFT instances driven in lockstep against a
// timestamped queue model.
module tb_fifo_sync_ext;
  import fifo_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST, FLUSH, WR_EN, RD_EN;
  logic [7:0] DIN;

  logic       full_s [2];
  logic       afull_s [2];
  logic       ovf_s [2];
  logic       empty_s [2];
  logic       aempty_s [2];
  logic       udf_s [2];
  logic [7:0] dout_s [2];
  logic [2:0] used_s [2];

  fifo_sync_ext #(.DWIDTH(8), .ADEPTH(2), .FWFT(FIFO_STD), .AFULL_LVL(3), .AEMPTY_LVL(1)) u_std (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .WR_EN(WR_EN), .DIN(DIN),
    .FULL(full_s[0]), .ALMOST_FULL(afull_s[0]), .OVERFLOW(ovf_s[0]),
    .RD_EN(RD_EN), .DOUT(dout_s[0]), .EMPTY(empty_s[0]), .ALMOST_EMPTY(aempty_s[0]),
    .UNDERFLOW(udf_s[0]), .USED(used_s[0])
  );

  fifo_sync_ext #(.DWIDTH(8), .ADEPTH(2), .FWFT(FIFO_FWFT), .AFULL_LVL(3), .AEMPTY_LVL(1)) u_fwft (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .WR_EN(WR_EN), .DIN(DIN),
    .FULL(full_s[1]), .ALMOST_FULL(afull_s[1]), .OVERFLOW(ovf_s[1]),
    .RD_EN(RD_EN), .DOUT(dout_s[1]), .EMPTY(empty_s[1]), .ALMOST_EMPTY(aempty_s[1]),
    .UNDERFLOW(udf_s[1]), .USED(used_s[1])
  );

  // Model: every accepted word is stored with the edge number that wrote it.
  // A head word is readable after edge e once it was written at edge <= e - m,
  // where m is 0 in standard mode and 1 in FWFT mode.
  localparam int N = 4096;
  logic [7:0] md [2][N];
  int         mw [2][N];
  int         nin [2];
  int         nout [2];
  int         cyc;
  logic [7:0] dexp;
  bit         dval;
  int         tests, fails;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit vis(input int m, input int e);
    if (nin[m] == nout[m]) return 1'b0;
    return mw[m][nout[m] % N] <= e - m;
  endfunction

  task automatic step(input bit r, input bit f, input bit w, input logic [7:0] d, input bit rd);
    bit    pre_vis [2];
    int    pre_cnt [2];
    bit    eo, eu;
    int    cnt;
    string nm;
    RST = r; FLUSH = f; WR_EN = w; DIN = d; RD_EN = rd;
    for (int m = 0; m < 2; m++) begin
      pre_vis[m] = vis(m, cyc);
      pre_cnt[m] = nin[m] - nout[m];
    end
    @(posedge CLK);
    #1;
    cyc++;
    for (int m = 0; m < 2; m++) begin
      nm = (m == 0) ? "std" : "fwft";
      eo = 1'b0;
      eu = 1'b0;
      if (r || f) begin
        nout[m] = nin[m];
      end else begin
        eo = w && (pre_cnt[m] == 4);
        eu = rd && !pre_vis[m];
        if (rd && pre_vis[m]) begin
          if (m == 0) begin
            dexp = md[0][nout[0] % N];
            dval = 1'b1;
          end
          nout[m]++;
        end
        if (w && pre_cnt[m] != 4) begin
          md[m][nin[m] % N] = d;
          mw[m][nin[m] % N] = cyc;
          nin[m]++;
        end
      end
      cnt = nin[m] - nout[m];
      chk({nm, "_used"},   used_s[m],   cnt);
      chk({nm, "_full"},   full_s[m],   cnt == 4);
      chk({nm, "_afull"},  afull_s[m],  cnt >= 3);
      chk({nm, "_aempty"}, aempty_s[m], cnt <= 1);
      chk({nm, "_empty"},  empty_s[m],  !vis(m, cyc));
      chk({nm, "_ovf"},    ovf_s[m],    eo);
      chk({nm, "_udf"},    udf_s[m],    eu);
      if (m == 0 && dval)          chk("std_dout",  dout_s[0], dexp);
      if (m == 1 && vis(1, cyc))   chk("fwft_dout", dout_s[1], md[1][nout[1] % N]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; FLUSH = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; DIN = '0;
    tests = 0; fails = 0; cyc = 0; dval = 1'b0; dexp = '0;
    for (int m = 0; m < 2; m++) begin nin[m] = 0; nout[m] = 0; end

    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    chk("rst_empty", empty_s[1], 1);

    // Fill to full, overflow, drain in standard order
    step(0, 0, 1, 8'h11, 0);
    step(0, 0, 1, 8'h22, 0);
    step(0, 0, 1, 8'h33, 0);
    chk("t1_afull_at3", afull_s[0], 1);
    chk("t1_notfull_at3", full_s[0], 0);
    step(0, 0, 1, 8'h44, 0);
    chk("t1_full_at4", full_s[0], 1);
    step(0, 0, 1, 8'h55, 0);
    chk("t1_ovf", ovf_s[0], 1);
    chk("t1_used_held", used_s[0], 4);
    step(0, 0, 0, 8'h00, 0);
    chk("t1_ovf_one_cycle", ovf_s[0], 0);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e;
      e = 8'(8'h11 * (k + 1));
      step(0, 0, 0, 8'h00, 1);
      chk("t1_std_dout", dout_s[0], e);
    end

    // Underflow, then write accepted while read rejected
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1);
    chk("t2_udf", udf_s[0], 1);
    chk("t2_used0", used_s[0], 0);
    step(0, 0, 1, 8'hA5, 1);
    chk("t2_udf_wr", udf_s[0], 1);
    chk("t2_used1", used_s[0], 1);

    // FWFT latency and back-to-back pops
    step(0, 1, 0, 8'h00, 0);
    step(0, 0, 1, 8'h5A, 0);
    chk("t3_empty_after_t", empty_s[1], 1);
    step(0, 0, 0, 8'h00, 0);
    chk("t3_empty_after_t1", empty_s[1], 0);
    chk("t3_dout_5a", dout_s[1], 8'h5A);
    step(0, 1, 0, 8'h00, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 8'hC0 + 8'(k), 0);
    step(0, 0, 0, 8'h00, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 8'h00, 1);
      if (k < 3) begin
        chk("t3_nobubble_dout", dout_s[1], 8'hC1 + 8'(k));
        chk("t3_nobubble_empty", empty_s[1], 0);
      end else begin
        chk("t3_empty_after4", empty_s[1], 1);
      end
    end

    // Full with simultaneous read/write, then steady state across wrap
    step(0, 1, 0, 8'h00, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 8'hD0 + 8'(k), 0);
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'hEE, 1);
    chk("t4_std_ovf", ovf_s[0], 1);
    chk("t4_std_used3", used_s[0], 3);
    chk("t4_fwft_ovf", ovf_s[1], 1);
    chk("t4_fwft_used3", used_s[1], 3);
    step(0, 1, 0, 8'h00, 0);
    step(0, 0, 1, 8'h50, 0);
    step(0, 0, 1, 8'h51, 0);
    step(0, 0, 0, 8'h00, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1, 8'h60 + 8'(k), 1);
      chk("t4_std_used2", used_s[0], 2);
      chk("t4_fwft_used2", used_s[1], 2);
    end

    // Flush beats a same-cycle write
    step(0, 1, 0, 8'h00, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 8'h90 + 8'(k), 0);
    step(0, 1, 1, 8'h99, 0);
    chk("t5_used0", used_s[1], 0);
    chk("t5_empty", empty_s[1], 1);
    chk("t5_no_ovf", ovf_s[0], 0);
    step(0, 0, 1, 8'h77, 0);
    step(0, 0, 0, 8'h00, 0);
    chk("t5_fwft_dout77", dout_s[1], 8'h77);
    step(0, 0, 0, 8'h00, 1);
    chk("t5_std_dout77", dout_s[0], 8'h77);

    // Reset mid-stream
    step(0, 0, 1, 8'hB1, 0);
    step(0, 0, 1, 8'hB2, 0);
    step(0, 0, 0, 8'h00, 0);
    step(1, 0, 1, 8'hB3, 1);
    chk("t6_used0", used_s[1], 0);
    chk("t6_empty", empty_s[1], 1);
    chk("t6_ovf0", ovf_s[1], 0);
    chk("t6_udf0", udf_s[1], 0);

    // Random traffic: write-heavy, read-heavy, balanced, bursty
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 400; i++) begin
        int wp;
        int rp;
        wp = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 50 : 90;
        rp = (ph == 0) ? 20 : (ph == 1) ? 80 : (ph == 2) ? 50 : 90;
        step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
